// File: rtl/writeback_unit.sv
// Write-back stage: merges ALU results with in-order load returns onto the
// single register-file write port and tracks outstanding loads for decode.
module writeback_unit #(
    parameter int unsigned LOAD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        load_issue,
    input  logic [3:0]  load_rd,
    output logic        load_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic [3:0]  rf_write_Rd,
    output logic [31:0] rf_write_data,
    output logic [15:0] busy_mask,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(LOAD_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [3:0]       fifo_mem [LOAD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic             fifo_empty, fifo_full;
    logic [3:0]       head_rd;

    logic             skid_valid, skid_valid_nxt;
    logic [3:0]       skid_rd, skid_rd_nxt;
    logic [31:0]      skid_data, skid_data_nxt;

    logic [3:0]       rf_rd_nxt;
    logic [31:0]      rf_data_nxt;
    logic [15:0]      busy_nxt;
    logic             err_nxt;

    logic             load_acc, alu_acc, mem_pop;

    // Ready signals depend only on registered state and load_rd
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign head_rd    = fifo_mem[rd_ptr[IDX_W-1:0]];

    assign alu_ready  = !skid_valid;
    assign load_ready = !fifo_full && !busy_mask[load_rd];

    assign load_acc   = load_issue && load_ready;
    assign alu_acc    = alu_valid && alu_ready;
    assign mem_pop    = mem_valid && !fifo_empty;

    // Write selection: memory return, then skid, then direct ALU, else idle r0
    always_comb begin
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        skid_valid_nxt = skid_valid;
        skid_rd_nxt    = skid_rd;
        skid_data_nxt  = skid_data;
        rf_rd_nxt      = 4'd0;
        rf_data_nxt    = 32'd0;
        busy_nxt       = busy_mask;
        err_nxt        = err;

        if (mem_pop) begin
            rf_rd_nxt         = head_rd;
            rf_data_nxt       = mem_data;
            rd_ptr_nxt        = rd_ptr + PTR_W'(1);
            busy_nxt[head_rd] = 1'b0;
            if (alu_acc) begin
                skid_valid_nxt = 1'b1;
                skid_rd_nxt    = alu_rd;
                skid_data_nxt  = alu_data;
            end
        end else if (skid_valid) begin
            rf_rd_nxt      = skid_rd;
            rf_data_nxt    = skid_data;
            skid_valid_nxt = 1'b0;
        end else if (alu_acc) begin
            rf_rd_nxt   = alu_rd;
            rf_data_nxt = alu_data;
        end

        // A refused load issue never reaches here, so set cannot race a clear
        if (load_acc) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (load_rd != 4'd0) begin
                busy_nxt[load_rd] = 1'b1;
            end
        end

        if (mem_valid && fifo_empty) begin
            err_nxt = 1'b1;
        end

        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            skid_valid    <= 1'b0;
            skid_rd       <= 4'd0;
            skid_data     <= 32'd0;
            rf_write_Rd   <= 4'd0;
            rf_write_data <= 32'd0;
            busy_mask     <= 16'd0;
            err           <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            skid_valid    <= skid_valid_nxt;
            skid_rd       <= skid_rd_nxt;
            skid_data     <= skid_data_nxt;
            rf_write_Rd   <= rf_rd_nxt;
            rf_write_data <= rf_data_nxt;
            busy_mask     <= busy_nxt;
            err           <= err_nxt;
        end
    end

    // Tag storage needs no reset; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (load_acc) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= load_rd;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed table-driven bench for writeback_unit: one vector per clock cycle.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        load_issue;
    logic [3:0]  load_rd;
    logic        load_ready;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [3:0]  rf_write_Rd;
    logic [31:0] rf_write_data;
    logic [15:0] busy_mask;
    logic        err;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.LOAD_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .load_issue   (load_issue),
        .load_rd      (load_rd),
        .load_ready   (load_ready),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .rf_write_Rd  (rf_write_Rd),
        .rf_write_data(rf_write_data),
        .busy_mask    (busy_mask),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Inputs for one cycle, ready values expected during it, outputs after its edge
    typedef struct packed {
        logic        rst;
        logic        av;
        logic [3:0]  ard;
        logic [31:0] adata;
        logic        li;
        logic [3:0]  lrd;
        logic        mv;
        logic [31:0] mdata;
        logic        ar;
        logic        lr;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [15:0] busy;
        logic        err;
    } vec_t;

    function automatic vec_t mk(logic r, logic av, logic [3:0] ard, logic [31:0] ad,
                                logic li, logic [3:0] lrd, logic mv, logic [31:0] md,
                                logic ar, logic lr, logic [3:0] rd, logic [31:0] d,
                                logic [15:0] b, logic e);
        vec_t v;
        v.rst = r;   v.av = av;   v.ard = ard; v.adata = ad;
        v.li = li;   v.lrd = lrd; v.mv = mv;   v.mdata = md;
        v.ar = ar;   v.lr = lr;   v.rd = rd;   v.data = d;
        v.busy = b;  v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        @(negedge clk);
        rst        = v.rst;
        alu_valid  = v.av;
        alu_rd     = v.ard;
        alu_data   = v.adata;
        load_issue = v.li;
        load_rd    = v.lrd;
        mem_valid  = v.mv;
        mem_data   = v.mdata;
        #1;
        chk({tag, " alu_ready"},  32'(alu_ready),  32'(v.ar));
        chk({tag, " load_ready"}, 32'(load_ready), 32'(v.lr));
        @(posedge clk);
        #1;
        chk({tag, " rf_write_Rd"},   32'(rf_write_Rd), 32'(v.rd));
        chk({tag, " rf_write_data"}, rf_write_data,    v.data);
        chk({tag, " busy_mask"},     32'(busy_mask),   32'(v.busy));
        chk({tag, " err"},           32'(err),         32'(v.err));
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 32'd0;
        load_issue = 1'b0; load_rd = 4'd0; mem_valid = 1'b0; mem_data = 32'd0;

        //            rst av ard adata    li lrd mv mdata      ar lr rd data     busy      err
        tbl.push_back(mk(0, 1, 3, 32'h11, 0, 0, 0, 0,          1, 1, 3, 32'h11, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 4, 32'h22, 0, 0, 0, 0,          1, 1, 4, 32'h22, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,          1, 1, 0, 0,      16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 5, 0, 0,          1, 1, 0, 0,      16'h0020, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 6, 0, 0,          1, 1, 0, 0,      16'h0060, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hAAAA,   1, 1, 5, 32'hAAAA, 16'h0040, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hBBBB,   1, 1, 6, 32'hBBBB, 16'h0000, 0));
        // Single-cycle collision: mem first, ALU from skid next cycle
        tbl.push_back(mk(0, 0, 0, 0,      1, 5, 0, 0,          1, 1, 0, 0,      16'h0020, 0));
        tbl.push_back(mk(0, 1, 7, 32'h77, 0, 0, 1, 32'hAAAA,   1, 1, 5, 32'hAAAA, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,          0, 1, 7, 32'h77, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,          1, 1, 0, 0,      16'h0000, 0));
        // Fill the FIFO, then refusals on full and on busy
        tbl.push_back(mk(0, 0, 0, 0,      1, 1, 0, 0,          1, 1, 0, 0,      16'h0002, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 2, 0, 0,          1, 1, 0, 0,      16'h0006, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 3, 0, 0,          1, 1, 0, 0,      16'h000E, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 4, 0, 0,          1, 1, 0, 0,      16'h001E, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 7, 0, 0,          1, 0, 0, 0,      16'h001E, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 8, 1, 32'h1001,   1, 0, 1, 32'h1001, 16'h001C, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 2, 0, 0,          1, 0, 0, 0,      16'h001C, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'h2002,   1, 1, 2, 32'h2002, 16'h0018, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'h3003,   1, 1, 3, 32'h3003, 16'h0010, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'h4004,   1, 1, 4, 32'h4004, 16'h0000, 0));
        // Return with empty FIFO, sticky err, load to r0
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hDEAD,   1, 1, 0, 0,      16'h0000, 1));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,          1, 1, 0, 0,      16'h0000, 1));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0,          1, 1, 0, 0,      16'h0000, 1));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'h5555,   1, 1, 0, 32'h5555, 16'h0000, 1));
        tbl.push_back(mk(0, 1, 9, 32'h99, 0, 0, 1, 32'hEEEE,   1, 1, 9, 32'h99, 16'h0000, 1));
        // Push and pop in the same cycle; load to a register being cleared
        tbl.push_back(mk(0, 0, 0, 0,      1, 10, 0, 0,         1, 1, 0, 0,      16'h0400, 1));
        tbl.push_back(mk(0, 0, 0, 0,      1, 11, 1, 32'hA0A0,  1, 1, 10, 32'hA0A0, 16'h0800, 1));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hB0B0,   1, 1, 11, 32'hB0B0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 0, 0,      1, 12, 0, 0,         1, 1, 0, 0,      16'h1000, 1));
        tbl.push_back(mk(0, 0, 0, 0,      1, 12, 1, 32'hC0C0,  1, 0, 12, 32'hC0C0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,          1, 1, 0, 0,      16'h0000, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset rf_write_Rd",   32'(rf_write_Rd), 32'd0);
        chk("reset rf_write_data", rf_write_data,    32'd0);
        chk("reset busy_mask",     32'(busy_mask),   32'd0);
        chk("reset err",           32'(err),         32'd0);
        chk("reset alu_ready",     32'(alu_ready),   32'd1);
        chk("reset load_ready",    32'(load_ready),  32'd1);

        foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

        // mem_valid held 3 cycles behind a collision; a second ALU result waits
        run(mk(0, 0, 0, 0,      1, 5, 0, 0,      1, 1, 0, 0,      16'h0020, 1), "a1");
        run(mk(0, 0, 0, 0,      1, 6, 0, 0,      1, 1, 0, 0,      16'h0060, 1), "a2");
        run(mk(0, 0, 0, 0,      1, 8, 0, 0,      1, 1, 0, 0,      16'h0160, 1), "a3");
        run(mk(0, 1, 7, 32'h77, 0, 0, 1, 32'h5,  1, 1, 5, 32'h5,  16'h0140, 1), "a4");
        run(mk(0, 1, 9, 32'h99, 0, 0, 1, 32'h6,  0, 1, 6, 32'h6,  16'h0100, 1), "a5");
        run(mk(0, 1, 9, 32'h99, 0, 0, 1, 32'h8,  0, 1, 8, 32'h8,  16'h0000, 1), "a6");
        run(mk(0, 1, 9, 32'h99, 0, 0, 0, 0,      0, 1, 7, 32'h77, 16'h0000, 1), "a7");
        run(mk(0, 1, 9, 32'h99, 0, 0, 0, 0,      1, 1, 9, 32'h99, 16'h0000, 1), "a8");
        run(mk(0, 0, 0, 0,      0, 0, 0, 0,      1, 1, 0, 0,      16'h0000, 1), "a9");

        // Reset with two loads outstanding and the skid full
        run(mk(0, 0, 0, 0,      1, 5, 0, 0,      1, 1, 0, 0,      16'h0020, 1), "b1");
        run(mk(0, 0, 0, 0,      1, 6, 0, 0,      1, 1, 0, 0,      16'h0060, 1), "b2");
        run(mk(0, 0, 0, 0,      1, 8, 0, 0,      1, 1, 0, 0,      16'h0160, 1), "b3");
        run(mk(0, 1, 7, 32'h77, 0, 0, 1, 32'h5,  1, 1, 5, 32'h5,  16'h0140, 1), "b4");
        run(mk(1, 1, 9, 32'h99, 0, 0, 0, 0,      0, 1, 0, 0,      16'h0000, 0), "b5");
        run(mk(0, 0, 0, 0,      0, 6, 0, 0,      1, 1, 0, 0,      16'h0000, 0), "b6");
        run(mk(0, 0, 0, 0,      0, 0, 1, 32'h6,  1, 1, 0, 0,      16'h0000, 1), "b7");
        run(mk(0, 0, 0, 0,      0, 0, 0, 0,      1, 1, 0, 0,      16'h0000, 1), "b8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
